// File: rtl/alu_nbit_seq_if.sv
// Operand/result bus for alu_nbit_seq.
// The master side drives operands and the opcode and accepts results; the
// slave side (the ALU) reports readiness and returns Result/Zero/Overflow.
interface alu_nbit_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   Operation;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;
    logic         Zero;
    logic         Overflow;

    modport master (
        output in_valid,
        output A,
        output B,
        output Operation,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Result,
        input  Zero,
        input  Overflow
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  Operation,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Result,
        output Zero,
        output Overflow
    );
endinterface

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: W-bit ALU (AND/OR/ADD/SUB/SLT/SLL/SRL) with registered
// Result/Zero/Overflow behind valid/ready handshakes on input and output.
// Define ALU_MUL_EN to add an iterative shift-add unsigned multiply on
// opcode 011 (one partial product per cycle, W+1 cycle latency). Without it,
// opcode 011 finishes in one cycle with Result=0, Zero=1, Overflow=0.
module alu_nbit_seq #(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          reset,
    alu_nbit_seq_if.slave bus
);
    localparam int SHW = $clog2(W);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;

`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam int         CW     = SHW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_t;
`endif

    state_t state;
    state_t state_next;
    state_t accept_target;

    logic         in_ready_c;
    logic         accept;
    logic [W-1:0] result_q;
    logic         zero_q;
    logic         ovf_q;

    logic [W-1:0] alu_result;
    logic         alu_ovf;
    logic [W-1:0] add_sum;
    logic [W-1:0] sub_diff;
    logic         add_ovf;
    logic         sub_ovf;
    logic         slt_less;
    logic [SHW-1:0] shamt;

    // A new operation can enter when idle, or when the held result leaves this cycle.
    assign in_ready_c = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign accept     = bus.in_valid & in_ready_c;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == DONE);
    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = ovf_q;

    assign add_sum  = bus.A + bus.B;
    assign sub_diff = bus.A - bus.B;
    assign add_ovf  = (bus.A[W-1] == bus.B[W-1]) & (add_sum[W-1] != bus.A[W-1]);
    assign sub_ovf  = (bus.A[W-1] != bus.B[W-1]) & (sub_diff[W-1] != bus.A[W-1]);
    assign slt_less = sub_diff[W-1] ^ sub_ovf;
    assign shamt    = bus.B[SHW-1:0];

`ifdef ALU_MUL_EN
    logic [W-1:0]   mcand;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [W:0]     partial_sum;
    logic [CW-1:0]  cnt;
    logic           last_step;
    logic           is_mul_op;

    assign is_mul_op     = (bus.Operation == OP_MUL);
    assign accept_target = is_mul_op ? BUSY : DONE;
    assign last_step     = (cnt == CW'(W - 1));
    assign partial_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    assign acc_next      = {partial_sum, acc[W-1:1]};

    // Multiplier: capture operands at accept, then one shift-add step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
        end else if (accept && is_mul_op) begin
            cnt   <= '0;
            acc   <= {{W{1'b0}}, bus.B};
            mcand <= bus.A;
        end else if (state == BUSY) begin
            cnt   <= cnt + CW'(1);
            acc   <= acc_next;
        end
    end
`else
    assign accept_target = DONE;
`endif

    // Single-cycle ALU result and overflow from the live operands at accept.
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (bus.Operation)
            OP_AND: alu_result = bus.A & bus.B;
            OP_OR:  alu_result = bus.A | bus.B;
            OP_ADD: begin
                alu_result = add_sum;
                alu_ovf    = add_ovf;
            end
            OP_SUB: begin
                alu_result = sub_diff;
                alu_ovf    = sub_ovf;
            end
            OP_SLT: begin
                alu_result = {{(W-1){1'b0}}, slt_less};
                alu_ovf    = sub_ovf;
            end
            OP_SLL: alu_result = bus.A << shamt;
            OP_SRL: alu_result = bus.A >> shamt;
            default: begin
                alu_result = '0;
                alu_ovf    = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accepts go straight to DONE or through BUSY for MUL.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = accept_target;
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_next = accept ? accept_target : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output registers: loaded at accept for single-cycle ops, at the last MUL step otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef ALU_MUL_EN
        end else if ((state == BUSY) && last_step) begin
            result_q <= acc_next[W-1:0];
            zero_q   <= (acc_next[W-1:0] == '0);
            ovf_q    <= |acc_next[2*W-1:W];
        end else if (accept && !is_mul_op) begin
`else
        end else if (accept) begin
`endif
            result_q <= alu_result;
            zero_q   <= (alu_result == '0);
            ovf_q    <= alu_ovf;
        end
    end
endmodule

// File: tb/tb_alu_nbit_seq.sv
// Self-checking bench for alu_nbit_seq at W=8 and W=4.
// An arithmetic reference model produces the expected result, flags and
// latency of each accepted operation; a scoreboard queue per instance holds
// them until the DUT hands the result over.
module tb_alu_nbit_seq;
    typedef struct {
        logic [7:0] result;
        logic       zero;
        logic       ovf;
        int         acc_cycle;
        int         latency;
    } exp_t;

    logic clk;
    logic reset;

    int checks_total;
    int checks_passed;

    exp_t exp_q [2][$];
    int   cyc [2];

    alu_nbit_seq_if #(.W(8)) bus8 ();
    alu_nbit_seq_if #(.W(4)) bus4 ();

    alu_nbit_seq #(.W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    alu_nbit_seq #(.W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, actual, expected, $time);
        end else begin
            checks_passed++;
        end
    endtask

    // Reference model: {Overflow, Zero, Result} for a w-bit ALU.
    function automatic logic [9:0] model(input int w, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] mask;
        logic [7:0] r;
        logic       o;
        int sa, sb, t, hi, lo, sh;
        mask = (w == 8) ? 8'hFF : 8'h0F;
        sa = a[w-1] ? int'(a) - (1 << w) : int'(a);
        sb = b[w-1] ? int'(b) - (1 << w) : int'(b);
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        sh = int'(b) % w;
        r  = 8'h00;
        o  = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin t = sa + sb; r = 8'(t) & mask; o = (t > hi) || (t < lo); end
            3'b110: begin t = sa - sb; r = 8'(t) & mask; o = (t > hi) || (t < lo); end
            3'b111: begin t = sa - sb; r = (sa < sb) ? 8'h01 : 8'h00; o = (t > hi) || (t < lo); end
            3'b100: r = 8'(int'(a) << sh) & mask;
            3'b101: r = a >> sh;
            default: begin
`ifdef ALU_MUL_EN
                t = int'(a) * int'(b);
                r = 8'(t) & mask;
                o = (t >> w) != 0;
`else
                r = 8'h00;
                o = 1'b0;
`endif
            end
        endcase
        return {o, (r == 8'h00), r};
    endfunction

    function automatic int latency_of(input int w, input logic [2:0] op);
`ifdef ALU_MUL_EN
        if (op == 3'b011) return w + 1;
`endif
        return 1;
    endfunction

    // Scoreboard step, run once per falling edge for one instance.
    task automatic monitorStep(input int d, input int w, input logic rst,
                               input logic iv, input logic ir, input logic ov, input logic ordy,
                               input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                               input logic [7:0] res, input logic z, input logic ovf);
        logic       exp_ov;
        logic       exp_ir;
        logic [9:0] m;
        exp_t       e;
        if (rst) begin
            exp_q[d].delete();
            return;
        end
        cyc[d]++;
        exp_ov = (exp_q[d].size() > 0) && ((cyc[d] - exp_q[d][0].acc_cycle) >= exp_q[d][0].latency);
        exp_ir = (exp_q[d].size() == 0) || (exp_ov && ordy);
        checkOutput($sformatf("w%0d out_valid", w), {31'b0, ov}, {31'b0, exp_ov});
        checkOutput($sformatf("w%0d in_ready", w), {31'b0, ir}, {31'b0, exp_ir});
        if (ov && exp_ov) begin
            checkOutput($sformatf("w%0d Result", w), {24'b0, res}, {24'b0, exp_q[d][0].result});
            checkOutput($sformatf("w%0d Zero", w), {31'b0, z}, {31'b0, exp_q[d][0].zero});
            checkOutput($sformatf("w%0d Overflow", w), {31'b0, ovf}, {31'b0, exp_q[d][0].ovf});
            if (ordy) void'(exp_q[d].pop_front());
        end
        if (iv && ir) begin
            m = model(w, op, a, b);
            e.result    = m[7:0];
            e.zero      = m[8];
            e.ovf       = m[9];
            e.acc_cycle = cyc[d];
            e.latency   = latency_of(w, op);
            exp_q[d].push_back(e);
        end
    endtask

    // Watch both instances on the falling edge, away from the active edge.
    always @(negedge clk) begin
        monitorStep(0, 8, reset, bus8.in_valid, bus8.in_ready, bus8.out_valid, bus8.out_ready,
                    bus8.A, bus8.B, bus8.Operation, bus8.Result, bus8.Zero, bus8.Overflow);
        monitorStep(1, 4, reset, bus4.in_valid, bus4.in_ready, bus4.out_valid, bus4.out_ready,
                    {4'b0, bus4.A}, {4'b0, bus4.B}, bus4.Operation, {4'b0, bus4.Result},
                    bus4.Zero, bus4.Overflow);
    end

    // Present one operation and hold it until accepted (bounded).
    task automatic applyStimulus(input int d, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic accepted;
        if (d == 0) begin
            bus8.A = a; bus8.B = b; bus8.Operation = op; bus8.in_valid = 1'b1;
        end else begin
            bus4.A = a[3:0]; bus4.B = b[3:0]; bus4.Operation = op; bus4.in_valid = 1'b1;
        end
        accepted = 1'b0;
        for (int i = 0; i < 60 && !accepted; i++) begin
            @(negedge clk);
            accepted = (d == 0) ? bus8.in_ready : bus4.in_ready;
            @(posedge clk);
            #1;
        end
        if (d == 0) bus8.in_valid = 1'b0;
        else        bus4.in_valid = 1'b0;
        if (!accepted) checkOutput("accept timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain(input int d);
        for (int i = 0; i < 60 && exp_q[d].size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput($sformatf("drain %0d", d), exp_q[d].size(), 32'd0);
    endtask

    task automatic checkReset(input int d);
        @(negedge clk);
        if (d == 0) begin
            checkOutput("rst out_valid", {31'b0, bus8.out_valid}, 32'd0);
            checkOutput("rst Result", {24'b0, bus8.Result}, 32'd0);
            checkOutput("rst Zero", {31'b0, bus8.Zero}, 32'd1);
            checkOutput("rst Overflow", {31'b0, bus8.Overflow}, 32'd0);
            checkOutput("rst in_ready", {31'b0, bus8.in_ready}, 32'd1);
        end else begin
            checkOutput("rst4 out_valid", {31'b0, bus4.out_valid}, 32'd0);
            checkOutput("rst4 Result", {28'b0, bus4.Result}, 32'd0);
            checkOutput("rst4 Zero", {31'b0, bus4.Zero}, 32'd1);
            checkOutput("rst4 Overflow", {31'b0, bus4.Overflow}, 32'd0);
            checkOutput("rst4 in_ready", {31'b0, bus4.in_ready}, 32'd1);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed and random stimulus sequence.
    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset = 1'b1;
        bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Operation = '0; bus8.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Operation = '0; bus4.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkReset(0);
        checkReset(1);

        // Back-to-back single-cycle ops on the 8-bit instance.
        applyStimulus(0, 3'b010, 8'h7F, 8'h01);
        applyStimulus(0, 3'b110, 8'h05, 8'h05);
        applyStimulus(0, 3'b100, 8'h81, 8'h03);
        applyStimulus(0, 3'b101, 8'h81, 8'h03);
        applyStimulus(0, 3'b000, 8'hF0, 8'h3C);
        applyStimulus(0, 3'b001, 8'hF0, 8'h0C);
        applyStimulus(0, 3'b111, 8'h80, 8'h01);
        applyStimulus(0, 3'b111, 8'h7F, 8'h80);
        applyStimulus(0, 3'b010, 8'h80, 8'h80);
        waitDrain(0);

        applyStimulus(0, 3'b011, 8'h0F, 8'h11);
        applyStimulus(0, 3'b011, 8'hFF, 8'hFF);
        waitDrain(0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        waitDrain(0);

        // Backpressure: hold the result 3 cycles, then take it and accept the next op together.
        bus8.out_ready = 1'b0;
        applyStimulus(0, 3'b010, 8'h12, 8'h34);
        fork
            applyStimulus(0, 3'b010, 8'h40, 8'h40);
            begin
                repeat (3) @(posedge clk);
                #1 bus8.out_ready = 1'b1;
            end
        join
        waitDrain(0);

        // Reset in the middle of a multiply: nothing may come out afterwards.
        applyStimulus(0, 3'b011, 8'h0F, 8'h11);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkReset(0);
        repeat (12) @(posedge clk);
        #1;

        // 4-bit instance: SLT overflow cases and the multiply example.
        applyStimulus(1, 3'b111, 8'h0D, 8'h06);
        applyStimulus(1, 3'b111, 8'h06, 8'h0D);
        applyStimulus(1, 3'b011, 8'h05, 8'h04);
        waitDrain(1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
        end
        waitDrain(1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/alu_nbit_seq.md
# alu_nbit_seq

Parametrised, handshaked successor to the 4-bit combinational ALU slice. Computes AND/OR/ADD/SUB/SLT plus logical shifts on W-bit operands with the same 3-bit operation encoding. Optionally adds an iterative multi-cycle unsigned multiply. Results are registered with Zero/Overflow flags. Sits between the operand register stage and writeback, behind a valid/ready handshake on both sides.

## Interface
Parameters:
- W, default 8: operand/result width; power of two, W ≥ 4.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an operation this cycle
- A  in  W  operand A (two's complement for ADD/SUB/SLT)
- B  in  W  operand B; shifts use B[$clog2(W)-1:0] as amount
- Operation  in  3  opcode (see Operation)
- out_valid  out  1  Result/flags valid
- out_ready  in  1  consumer accepts result
- Result  out  W  registered result
- Zero  out  1  Result == 0
- Overflow  out  1  operation-specific overflow flag

## Operation
- Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB (A−B), 111 SLT, 100 SLL (A << sh), 101 SRL (A >> sh, zero fill), 011 MUL (ALU_MUL_EN only).
- ADD/SUB: W-bit wrap-around; Overflow = signed overflow (operand signs equal under the effective add, result sign differs).
- SLT: less = sign(A−B) XOR sub_overflow; Result = {W−1 zeros, less}; Overflow = sub_overflow. Example W=4: A=1101, B=0110 → Result 0001, Overflow 1.
- AND/OR/SLL/SRL: Overflow = 0.
- MUL: unsigned shift-add, one partial-product step per cycle, 2W-bit internal product; Result = low W bits; Overflow = |high W bits.
- Zero is computed from the final Result, for every opcode.
- Operands and opcode are captured at accept; later input changes have no effect.
- FSM: IDLE, BUSY (MUL only), DONE.
  - IDLE: accept → DONE for single-cycle ops, BUSY for MUL (step counter cleared).
  - BUSY: counter increments each cycle; after W steps → DONE.
  - DONE: out_valid=1; Result/flags held stable until out_ready. On out_ready, a simultaneous accept starts the next op (back-to-back); otherwise → IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, Result=0, Zero=1, Overflow=0; step counter 0.
- Single-cycle ops: accept at edge t → out_valid=1 after edge t. Latency 1 cycle; throughput 1/cycle with out_ready held high.
- MUL: accept at edge t, steps at edges t+1..t+W, out_valid=1 after edge t+W. Latency W+1 cycles. in_ready=0 during BUSY.
- Backpressure: with out_ready=0 in DONE, all outputs are frozen indefinitely.
- Reset asserted in any state (including mid-MUL) → next edge returns all reset values; the in-flight op is discarded with no output.
- in_valid while in_ready=0 is ignored; the source must hold it.

## Configuration
- ALU_MUL_EN defined: MUL opcode 011 implemented as above; BUSY state and step counter present.
- ALU_MUL_EN undefined: no BUSY state, counter, or multiplier datapath. Opcode 011 completes in 1 cycle with Result=0, Zero=1, Overflow=0. All ops are single-cycle.

## Test plan
- Reset: hold reset 2 cycles mid-MUL (W=8) → after edge, out_valid=0, Result=0, Zero=1, Overflow=0, in_ready=1; no late result appears.
- SLT overflow, W=4: A=1101, B=0110, op 111 → Result 0001, Zero 0, Overflow 1. Also A=0110, B=1101 → Result 0000, Zero 1, Overflow 1.
- ADD/SUB wrap, W=8: 0x7F+0x01 → 0x80, Overflow 1; 0x05−0x05 (op 110) → 0x00, Zero 1, Overflow 0.
- Shifts, W=8: A=0x81, B=0x03, op 100 → 0x08; op 101 → 0x10; Overflow 0 in both.
- MUL (ALU_MUL_EN), W=4: A=0101, B=0100 → out_valid exactly 5 cycles after accept, Result 0100, Overflow 1. With macro off: same stimulus → Result 0000, Zero 1, 1-cycle latency.
- Handshake: back-to-back ADDs with out_ready=1 → one result per cycle. Drop out_ready for 3 cycles → Result held and in_ready=0; the new op is accepted on the same edge the held result is taken.
